// File: rtl/fetch_sequencer.sv
// Fetch sequencer: reads NUM_ROWS consecutive 64-bit words, one outstanding at a time,
// and unpacks each word MSB-first into that row's byte FIFO, honouring per-row backpressure.
module fetch_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_ROWS   = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    output logic                  o_mem_read,
    output logic [ADDR_WIDTH-1:0] o_mem_address,
    input  logic [63:0]           i_mem_readdata,
    input  logic                  i_mem_readdatavalid,
    input  logic                  i_mem_waitrequest,
    input  logic [NUM_ROWS-1:0]   i_fifo_full,
    output logic [NUM_ROWS-1:0]   o_fifo_wr_en,
    output logic [DATA_WIDTH-1:0] o_fifo_wdata,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int BYTES = 64 / DATA_WIDTH;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES - 1);
    localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(NUM_ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_DATA,
        S_UNPACK,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [ROW_W-1:0]      r_row;
    logic [ROW_W-1:0]      w_row_next;
    logic [CNT_W-1:0]      r_byte_cnt;
    logic [CNT_W-1:0]      w_byte_cnt_next;
    logic [63:0]           r_word_q;
    logic [63:0]           w_word_next;
    logic [ADDR_WIDTH-1:0] r_base_q;
    logic [ADDR_WIDTH-1:0] w_base_next;
    logic [63:0]           w_shifted;
    logic                  w_row_full;

    // Shifting the current byte to the top keeps the select constant (MSB-first order).
    assign w_shifted  = r_word_q << (DATA_WIDTH * int'(r_byte_cnt));
    assign w_row_full = i_fifo_full[r_row];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_row      <= '0;
            r_byte_cnt <= '0;
            r_word_q   <= '0;
            r_base_q   <= '0;
        end else begin
            r_state    <= w_state_next;
            r_row      <= w_row_next;
            r_byte_cnt <= w_byte_cnt_next;
            r_word_q   <= w_word_next;
            r_base_q   <= w_base_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_row_next      = r_row;
        w_byte_cnt_next = r_byte_cnt;
        w_word_next     = r_word_q;
        w_base_next     = r_base_q;
        o_mem_read      = 1'b0;
        o_mem_address   = '0;
        o_fifo_wr_en    = '0;
        o_fifo_wdata    = '0;
        o_busy          = (r_state != S_IDLE);
        o_done          = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_base_next     = i_base_addr;
                    w_row_next      = '0;
                    w_byte_cnt_next = '0;
                    w_state_next    = S_REQ;
                end
            end
            S_REQ: begin
                o_mem_read    = 1'b1;
                o_mem_address = r_base_q + ADDR_WIDTH'(r_row);
                if (!i_mem_waitrequest) begin
                    // Zero-latency memories may return data in the accept cycle itself.
                    if (i_mem_readdatavalid) begin
                        w_word_next     = i_mem_readdata;
                        w_byte_cnt_next = '0;
                        w_state_next    = S_UNPACK;
                    end else begin
                        w_state_next = S_WAIT_DATA;
                    end
                end
            end
            S_WAIT_DATA: begin
                if (i_mem_readdatavalid) begin
                    w_word_next     = i_mem_readdata;
                    w_byte_cnt_next = '0;
                    w_state_next    = S_UNPACK;
                end
            end
            S_UNPACK: begin
                o_fifo_wdata = w_shifted[63 -: DATA_WIDTH];
                if (!w_row_full) begin
                    o_fifo_wr_en    = NUM_ROWS'(1) << r_row;
                    w_byte_cnt_next = r_byte_cnt + 1'b1;
                    if (r_byte_cnt == LAST_BYTE) begin
                        if (r_row == LAST_ROW) begin
                            w_state_next = S_DONE;
                        end else begin
                            w_row_next   = r_row + 1'b1;
                            w_state_next = S_REQ;
                        end
                    end
                end
            end
            S_DONE: begin
                o_done       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

endmodule
